// File: rtl/jtframe_mr_ddrarb.sv
// jtframe_mr_ddrarb
//   Burst-aware arbiter sharing the DDR3 Avalon port between the ROM loader
//   (read-only) and the rotation frame buffer (read/write). Ownership is
//   registered and only changes in IDLE, so a burst is never cut short.
//
//   Optional feature macro: JTFRAME_MR_DDRARB_RR_EN
//     defined   : round-robin between ld and rot when both are eligible
//     undefined : fixed priority, ld wins while downloading
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   downloading                ROM download in progress (gates ld requests)
//   ld_*                       loader request / wait / read-valid
//   rot_*                      rotation request / wait / read-valid
//   ddr_busy, ddr_dout_ready   DDR wait request and read-data valid
//   ddr_*  (outputs)           command to DDR, combinational from state/owner
`timescale 1ns/1ps
module jtframe_mr_ddrarb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [ 7:0] ld_burstcnt,
    input  logic [28:0] ld_addr,
    input  logic        ld_rd,
    output logic        ld_busy,
    output logic        ld_dout_ready,
    input  logic [ 7:0] rot_burstcnt,
    input  logic [28:0] rot_addr,
    input  logic        rot_rd,
    input  logic        rot_we,
    input  logic [ 7:0] rot_be,
    input  logic [63:0] rot_din,
    output logic        rot_busy,
    output logic        rot_dout_ready,
    input  logic        ddr_busy,
    input  logic        ddr_dout_ready,
    output logic [ 7:0] ddr_burstcnt,
    output logic [28:0] ddr_addr,
    output logic        ddr_rd,
    output logic        ddr_we,
    output logic [ 7:0] ddr_be,
    output logic [63:0] ddr_din
);

    typedef enum logic [1:0] {IDLE, CMD, RDWAIT, WRBURST} state_t;

    state_t     state, state_nx;
    logic       owner, owner_nx;     // 0 = ld, 1 = rot
    logic [7:0] beats, beats_nx;
    logic       last,  last_nx;

    logic       ld_elig, rot_elig, grant;
    logic [7:0] own_bc, own_len;

    assign ld_elig  = downloading & ld_rd;
    assign rot_elig = rot_rd | rot_we;

`ifdef JTFRAME_MR_DDRARB_RR_EN
    assign grant = (ld_elig & rot_elig) ? ~last : ~ld_elig;
`else
    assign grant = ~ld_elig;
`endif

    // A burst count of zero counts as a single beat
    assign own_bc  = owner ? rot_burstcnt : ld_burstcnt;
    assign own_len = (own_bc == 8'd0) ? 8'd1 : own_bc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
            beats <= '0;
            last  <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            beats <= beats_nx;
            last  <= last_nx;
        end
    end

    // DDR command, busy and read-valid routing
    always_comb begin
        ddr_burstcnt   = '0;
        ddr_addr       = '0;
        ddr_rd         = 1'b0;
        ddr_we         = 1'b0;
        ddr_be         = '0;
        ddr_din        = '0;
        ld_busy        = 1'b1;
        rot_busy       = 1'b1;
        ld_dout_ready  = 1'b0;
        rot_dout_ready = 1'b0;
        case (state)
            CMD: begin
                if (owner) begin
                    ddr_burstcnt = rot_burstcnt;
                    ddr_addr     = rot_addr;
                    ddr_rd       = rot_rd;
                    ddr_we       = rot_we;
                    ddr_be       = rot_be;
                    ddr_din      = rot_din;
                    rot_busy     = ddr_busy;
                end else begin
                    ddr_burstcnt = ld_burstcnt;
                    ddr_addr     = ld_addr;
                    ddr_rd       = ld_rd;
                    ddr_be       = '1;
                    ld_busy      = ddr_busy;
                end
            end
            WRBURST: begin
                ddr_burstcnt = rot_burstcnt;
                ddr_addr     = rot_addr;
                ddr_we       = rot_we;
                ddr_be       = rot_be;
                ddr_din      = rot_din;
                rot_busy     = ddr_busy;
            end
            RDWAIT: begin
                if (owner) rot_dout_ready = ddr_dout_ready;
                else       ld_dout_ready  = ddr_dout_ready;
            end
            default: ;
        endcase
    end

    // Next state
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        beats_nx = beats;
        last_nx  = last;
        case (state)
            IDLE: begin
                if (ld_elig | rot_elig) begin
                    owner_nx = grant;
`ifdef JTFRAME_MR_DDRARB_RR_EN
                    last_nx  = grant;
`endif
                    state_nx = CMD;
                end
            end
            CMD: begin
                if (ddr_rd & ~ddr_busy) begin
                    beats_nx = own_len;
                    state_nx = RDWAIT;
                end else if (ddr_we & ~ddr_busy) begin
                    if (own_len == 8'd1) begin
                        state_nx = IDLE;
                    end else begin
                        beats_nx = own_len - 8'd1;
                        state_nx = WRBURST;
                    end
                end else if (~ddr_rd & ~ddr_we) begin
                    state_nx = IDLE;
                end
            end
            RDWAIT: begin
                if (ddr_dout_ready) begin
                    beats_nx = (beats == 8'd0) ? 8'd0 : beats - 8'd1;
                    if (beats <= 8'd1) state_nx = IDLE;
                end
            end
            WRBURST: begin
                if (ddr_we & ~ddr_busy) begin
                    beats_nx = (beats == 8'd0) ? 8'd0 : beats - 8'd1;
                    if (beats <= 8'd1) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: doc/jtframe_mr_ddrarb.md
# jtframe_mr_ddrarb

Burst-aware arbiter sharing the MiSTer DDR3 Avalon port between the fast ROM loader (read-only) and the rotation frame buffer (read/write). It replaces a combinational select with a registered owner that changes only at burst boundaries. No transfer can be cut mid-burst when `downloading` toggles. It sits between the loader/rotation blocks and the top-level DDR signals.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock; DDR port runs on it.
- `rst_n` in 1: asynchronous, active-low reset.
- `downloading` in 1: ROM download in progress.
- `ld_burstcnt` in 8: loader burst length.
- `ld_addr` in 29: loader address.
- `ld_rd` in 1: loader read request.
- `ld_busy` out 1: loader wait request.
- `ld_dout_ready` out 1: loader read-data valid.
- `rot_burstcnt` in 8: rotation burst length.
- `rot_addr` in 29: rotation address.
- `rot_rd` in 1: rotation read request.
- `rot_we` in 1: rotation write request.
- `rot_be` in 8: rotation byte enables.
- `rot_din` in 64: rotation write data.
- `rot_busy` out 1: rotation wait request.
- `rot_dout_ready` out 1: rotation read-data valid.
- `ddr_busy` in 1: DDR wait request.
- `ddr_dout_ready` in 1: DDR read-data valid.
- `ddr_burstcnt` out 8: to DDR.
- `ddr_addr` out 29: to DDR.
- `ddr_rd` out 1: to DDR.
- `ddr_we` out 1: to DDR.
- `ddr_be` out 8: to DDR.
- `ddr_din` out 64: to DDR.

## Operation
- State machine states: IDLE, CMD, RDWAIT, WRBURST. Registers: `owner` (0 = ld, 1 = rot), 8-bit `beats` counter, `last` grant pointer.
- IDLE:
  - Eligible requesters: ld when `downloading & ld_rd`; rot when `rot_rd | rot_we`.
  - With no eligible requester, stay in IDLE.
  - Otherwise latch `owner` and go to CMD.
  - With `downloading`=0, ld requests are ignored.
- CMD:
  - `ddr_*` mirror the owner's request.
  - For the ld owner: `ddr_we`=0, `ddr_be`=8'hFF, `ddr_din`=0.
  - Read accepted (`ddr_rd & ~ddr_busy`): `beats` ← burstcnt, then go to RDWAIT.
  - Write beat accepted (`ddr_we & ~ddr_busy`):
    - burstcnt = 1 → IDLE.
    - Otherwise `beats` ← burstcnt−1 and go to WRBURST.
  - Owner drops its request before acceptance → IDLE.
- RDWAIT:
  - `ddr_rd`=0 and `ddr_we`=0.
  - Each `ddr_dout_ready` decrements `beats` and is routed only to the owner's `*_dout_ready`.
  - `beats` reaching 0 → IDLE.
- WRBURST:
  - Rot owner only; mirrors `rot_we`, `rot_be`, `rot_din`, `rot_addr`.
  - Each accepted beat decrements `beats`; the final beat → IDLE.
- Busy outputs:
  - Owner in CMD or WRBURST: busy = `ddr_busy`.
  - All other cases: busy = 1. This includes the owner in RDWAIT, any non-owner, and IDLE.
- Outside CMD and WRBURST, all `ddr_*` outputs are 0.
- Burst length rule: burstcnt 0 is treated as 1 in both read and write counting. Counter arithmetic is 8-bit and has no wrap.
- `ddr_dout_ready` arriving outside RDWAIT is dropped and routed to no port.
- `downloading` falling while ld owns a burst: the burst completes normally. Subsequent ld requests are ignored.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State IDLE; `owner`=0, `beats`=0, `last`=0.
  - `ddr_rd`=0, `ddr_we`=0, `ddr_be`=0, `ddr_burstcnt`=0, `ddr_addr`=0, `ddr_din`=0.
  - `ld_busy`=1, `rot_busy`=1.
  - `ld_dout_ready`=0, `rot_dout_ready`=0.
  - Reset mid-burst aborts immediately; outstanding DDR beats after release are dropped.
- Grant latency: request seen in IDLE at edge N → CMD at N+1. `ddr_*` are valid and owner busy follows `ddr_busy` from N+1.
- Burst end → IDLE for exactly one cycle (re-arbitration). Minimum gap between two bursts is 2 cycles.
- `*_dout_ready` is combinational from `ddr_dout_ready`, with zero latency.
- All `ddr_*` outputs are combinational from state, `owner` and the owner's inputs.

## Configuration
- `JTFRAME_MR_DDRARB_RR_EN` defined:
  - When ld and rot are both eligible in IDLE, grant the port not recorded in `last`.
  - `last` updates on every grant.
- Not defined: fixed priority, with ld always winning while `downloading`=1. `last` is unused (held 0).

## Test plan
- Reset, then `downloading`=1, `ld_rd`=1, burstcnt=4, addr=0x100, `ddr_busy`=0, four `ddr_dout_ready` pulses → `ddr_rd`=1 with addr 0x100 one cycle after request; `ld_dout_ready` pulses 4 times; state returns to IDLE; `rot_busy`=1 throughout.
- `downloading`=0, rot write burstcnt=3, `be`=0x0F, `ddr_busy` high on the 2nd beat for 2 cycles → exactly 3 accepted beats with `ddr_be`=0x0F; `rot_busy` mirrors `ddr_busy`; IDLE after the 3rd beat.
- ld read burstcnt=8 in RDWAIT, `downloading` drops after 3 beats → remaining 5 beats go to `ld_dout_ready`; the next `ld_rd` is ignored and rot is granted.
- Both ld and rot requesting continuously with `downloading`=1: with RR_EN, grants alternate ld, rot, ld, rot; without RR_EN, every grant goes to ld.
- `rst_n` pulsed low during a rot write burst → `ddr_we`=0 and both busy outputs =1 asynchronously; a stray `ddr_dout_ready` after reset is dropped.
- burstcnt=0 read → one `ddr_dout_ready` returns the arbiter to IDLE.
